// File: rtl/hand_sensor_conditioner.sv
// hand_sensor_conditioner
//
// Turns the two raw hand-proximity sensor lines into the clean 2-bit hand
// code used by the LED/audio state machine. Each channel is synchronized,
// sampled on a slow tick and debounced. Channel changes that land close
// together are merged, so a two-hand gesture never shows a transient 01/10
// code. A channel that stays asserted too long is treated as a fault, and
// the published code is then forced to 00.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   sens_raw     raw sensor lines, asynchronous to clk
//                (bit 1 = left hand, bit 0 = right hand)
//   hand         published hand code, registered
//   hand_changed one-cycle pulse on the cycle hand takes a new value
//   fault        a channel is stuck asserted, registered

module hand_sensor_conditioner #(
    parameter int CLK_HZ            = 100_000_000,
    parameter int SAMPLE_HZ         = 1000,
    parameter int DEBOUNCE_SAMPLES  = 20,
    parameter int COINCIDE_SAMPLES  = 10,
    parameter int STUCK_SAMPLES     = 30000,
    parameter bit SENSOR_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sens_raw,
    output logic [1:0] hand,
    output logic       hand_changed,
    output logic       fault
);

    localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int TICK_W   = $clog2(TICK_DIV);
    localparam int DEB_W    = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
    localparam int WIN_W    = (COINCIDE_SAMPLES > 0) ? $clog2(COINCIDE_SAMPLES + 1) : 1;
    localparam int STK_W    = $clog2(STUCK_SAMPLES + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_SAMPLES - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(COINCIDE_SAMPLES);
    localparam logic [STK_W-1:0]  STK_MAX   = STK_W'(STUCK_SAMPLES);
    localparam bit                NO_WINDOW = (COINCIDE_SAMPLES == 0);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    logic [1:0]        sync_a;
    logic [1:0]        s;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [1:0]        stable;
    logic [DEB_W-1:0]  deb_cnt   [2];
    logic [STK_W-1:0]  stuck_cnt [2];
    logic [STK_W-1:0]  stuck_nxt [2];
    logic [1:0]        tgt;
    logic              both_diff;
    logic [WIN_W-1:0]  win_cnt;
    logic              win_done;
    state_t            state;
    state_t            state_nxt;
    logic              publish;
    logic              win_clr;
    logic              win_inc;

    // Two-flop synchronizer. Polarity is folded in ahead of the first flop,
    // so both stages hold "1 = hand present" and reset to "absent".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            s      <= '0;
        end else begin
            sync_a <= sens_raw ^ {2{SENSOR_ACTIVE_LOW}};
            s      <= sync_a;
        end
    end

    // Free-running sample divider; tick marks its terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Per-channel debounce. Any sample that agrees with the current stable
    // value restarts the count, so only an unbroken run of differing samples
    // flips the channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable     <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else if (tick) begin
            for (int i = 0; i < 2; i++) begin
                if (s[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    stable[i]  <= ~stable[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Stuck-asserted counters. They look at the stable value from before
    // this tick, which is why fault drops one tick after the channel releases.
    always_comb begin
        stuck_nxt[0] = stuck_cnt[0];
        stuck_nxt[1] = stuck_cnt[1];
        if (tick) begin
            for (int i = 0; i < 2; i++) begin
                if (!stable[i]) begin
                    stuck_nxt[i] = '0;
                end else if (stuck_cnt[i] != STK_MAX) begin
                    stuck_nxt[i] = stuck_cnt[i] + 1'b1;
                end
            end
        end
    end

    // The fault flag is registered from the next counter values so that it
    // moves on the same edge as the counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stuck_cnt[0] <= '0;
            stuck_cnt[1] <= '0;
            fault        <= 1'b0;
        end else begin
            stuck_cnt[0] <= stuck_nxt[0];
            stuck_cnt[1] <= stuck_nxt[1];
            fault        <= (stuck_nxt[0] == STK_MAX) || (stuck_nxt[1] == STK_MAX);
        end
    end

    assign tgt       = fault ? 2'b00 : stable;
    assign both_diff = ((tgt ^ hand) == 2'b11);
    assign win_done  = (win_cnt == WIN_LAST);

    // Publish FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state. A one-bit change waits in HOLD so that a second channel
    // arriving shortly after can be published together with it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((tgt != hand) && !(NO_WINDOW || fault || both_diff)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if ((tgt == hand) || both_diff || fault || win_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: when to publish and how to drive the merge-window counter.
    always_comb begin
        publish = 1'b0;
        win_clr = 1'b0;
        win_inc = 1'b0;
        case (state)
            IDLE: begin
                if (tgt != hand) begin
                    if (NO_WINDOW || fault || both_diff) begin
                        publish = 1'b1;
                    end else begin
                        win_clr = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tgt != hand) begin
                    if (both_diff || fault || win_done) begin
                        publish = 1'b1;
                    end else begin
                        win_inc = tick;
                    end
                end
            end
            default: ;
        endcase
    end

    // Published code, change pulse and the merge-window tick counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hand         <= 2'b00;
            hand_changed <= 1'b0;
            win_cnt      <= '0;
        end else begin
            hand_changed <= publish;
            if (publish) begin
                hand <= tgt;
            end
            if (win_clr) begin
                win_cnt <= '0;
            end else if (win_inc) begin
                win_cnt <= win_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/hand_sensor_conditioner.md
# hand_sensor_conditioner

Conditions the two raw hand-proximity sensor lines into the clean 2-bit `hand` code consumed by the LED/audio state machine. It synchronizes, samples and debounces each channel, merges near-simultaneous channel changes so two-hand gestures never show a transient 01/10 code, and masks a stuck sensor. It sits directly upstream of the LED/audio FSM on the 100 MHz system clock.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `SAMPLE_HZ`, 1000: sample tick rate. `CLK_HZ/SAMPLE_HZ` must be an integer ≥ 2.
- `DEBOUNCE_SAMPLES`, 20: consecutive differing samples needed to flip a channel (≥ 1).
- `COINCIDE_SAMPLES`, 10: merge window in ticks (0 = no window).
- `STUCK_SAMPLES`, 30000: ticks a channel may stay asserted before it is declared a fault.
- `SENSOR_ACTIVE_LOW`, 1: 1 = raw line low means hand present.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sens_raw`  in  2  raw sensor lines, asynchronous to `clk`. Bit 1 is the left hand, bit 0 is the right hand.
- `hand`  out  2  published hand code, registered.
- `hand_changed`  out  1  single-cycle pulse on the cycle `hand` takes a new value.
- `fault`  out  1  a channel is stuck asserted, registered.

## Operation
- Synchronizer: 2 flops per channel. The result is XORed with `SENSOR_ACTIVE_LOW`, giving `s[i]`, where 1 = present.
- Tick: a counter runs 0..`CLK_HZ/SAMPLE_HZ`-1 and wraps. `tick` = 1 for one clk at the terminal count. It free-runs from reset.
- Debounce, per channel, evaluated only on `tick`:
  - If `s[i]` equals `stable[i]`, the agree counter clears.
  - Otherwise the counter increments.
  - When it would reach `DEBOUNCE_SAMPLES`, `stable[i]` toggles and the counter clears.
- Stuck detect, per channel, evaluated on `tick`:
  - While `stable[i]`=1, the stuck counter increments, saturating at `STUCK_SAMPLES`.
  - When `stable[i]`=0, it clears.
  - `fault` = either counter saturated.
- Target code: `tgt` = `fault` ? 2'b00 : `stable`.
- Publish FSM states:
  - IDLE:
    - If `tgt` == `hand`, stay in IDLE.
    - Else, if `COINCIDE_SAMPLES`=0, or `fault`, or both bits of `tgt` differ from `hand`, publish next edge.
    - Else, clear the window counter and go to HOLD.
  - HOLD:
    - If `tgt` == `hand`, abort to IDLE with no publish.
    - Else, if both bits differ, or the window counter == `COINCIDE_SAMPLES` (incremented on `tick`), publish and go to IDLE.
  - Publish: `hand` <= `tgt`, `hand_changed` <= 1 for exactly one clk.
- Fault masking: `hand` is forced to 00 (published immediately, with a pulse if it changed).
  - Fault clears the tick after the stuck channel's `stable` returns to 0.
  - Publishing then resumes normally.

## Timing
- Reset, async assert:
  - `hand`=00, `hand_changed`=0, `fault`=0.
  - `stable`=00, synchronizers 0 (post-polarity), all counters 0, FSM=IDLE.
  - Effect is immediate.
  - Release is sampled on the next `clk` edge.
- Raw-to-`stable` latency: 2 clk (sync) + time to next `tick` + (`DEBOUNCE_SAMPLES`-1) tick periods.
- `stable`-to-`hand` latency:
  - 1 clk with no window, on fault, or when both bits change.
  - Otherwise `COINCIDE_SAMPLES` ticks + 1 clk.
- A pulse shorter than `DEBOUNCE_SAMPLES` tick periods never changes `hand`. A bouncing sample resets that channel's count.
- Both channels flipping on the same tick count as a two-bit change and are published once.
- The second channel flipping inside HOLD publishes on the next clk, with one pulse total.
- `hand_changed` never asserts on consecutive cycles. `hand` is constant between pulses.
- Counter widths hold their maximum values without wrap. Stuck counters saturate and never wrap.

## Test plan
Parameters for every scenario: `CLK_HZ`=1000, `SAMPLE_HZ`=100 (tick every 10 clk), `DEBOUNCE_SAMPLES`=4, `COINCIDE_SAMPLES`=3, `STUCK_SAMPLES`=50, `SENSOR_ACTIVE_LOW`=1.
- Reset: drive `reset`=0 with `sens_raw`=11 -> `hand`=00, `hand_changed`=0, `fault`=0. Release -> outputs unchanged for ≥ 100 clk.
- Glitch reject: `sens_raw`=10 for 25 clk (≤ 3 samples), then 11 -> `hand` stays 00, no pulse.
- Single hand: `sens_raw`=10, held (bit 0 present). Expect `hand`=01 after 4 ticks + 3 ticks + 1 clk (≈ 70–80 clk), with exactly one pulse. Release -> returns to 00 with one pulse.
- Two-hand merge: bit 0 asserted, bit 1 asserted 1 tick later -> `hand` goes 00 directly to 11, never 01 or 10, with one pulse.
- Stuck: hold `sens_raw`=00 -> `hand`=11, then after 50 ticks `fault`=1 and `hand`=00 with a pulse. Release to 11 -> `fault`=0 one tick after debounce, `hand` stays 00.
- Reset mid-HOLD: assert `reset` during the window -> `hand`=00 and the FSM is in IDLE immediately. No pulse after release while `sens_raw`=11.
